// File: rtl/shift_word_deser.sv
// rtl/shift_word_deser.sv - serial-to-parallel word assembler with one-word valid/ready holding buffer
// Optional trailing even-parity bit per word: define SHIFT_WORD_DESER_PARITY_EN
module shift_word_deser #(
  parameter int C_WIDTH     = 16,
  parameter int C_BIT_ORDER = 0
) (
  input  logic               CLK,
  input  logic               SCLR,
  input  logic               SDIN,
  input  logic               SDIN_VALID,
  input  logic               SYNC,
  output logic [C_WIDTH-1:0] Q,
  output logic               Q_VALID,
  input  logic               Q_READY,
  output logic               BUSY,
  output logic               OVERFLOW,
  output logic               PERR
);

`ifdef SHIFT_WORD_DESER_PARITY_EN
  localparam int L = C_WIDTH + 1;
`else
  localparam int L = C_WIDTH;
`endif
  localparam int            CW       = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  logic [C_WIDTH-1:0] sh;
  logic [C_WIDTH-1:0] sh_base;
  logic [C_WIDTH-1:0] sh_shifted;
  logic [C_WIDTH-1:0] word;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_base;
  logic [CW-1:0]      cnt_next;
  logic               last_bit;
  logic               shift_en;
  logic               complete;
  logic               load;
  logic               handshake;

  // SYNC restarts alignment: the current bit (if any) is treated as bit 0 of a fresh word
  assign sh_base  = SYNC ? '0 : sh;
  assign cnt_base = SYNC ? '0 : cnt;
  assign last_bit = (cnt_base == CNT_LAST);
  assign complete = SDIN_VALID & last_bit;

  generate
    if (C_WIDTH == 1) begin : g_one
      assign sh_shifted = SDIN;
    end else if (C_BIT_ORDER == 0) begin : g_msb_first
      assign sh_shifted = {sh_base[C_WIDTH-2:0], SDIN};
    end else begin : g_lsb_first
      assign sh_shifted = {SDIN, sh_base[C_WIDTH-1:1]};
    end
  endgenerate

`ifdef SHIFT_WORD_DESER_PARITY_EN
  logic word_perr;
  // the trailing parity bit is checked, never shifted into the data word
  assign shift_en  = SDIN_VALID & ~last_bit;
  assign word      = sh_base;
  assign word_perr = (^sh_base) ^ SDIN;
`else
  // the completing bit is the last data bit, so the offered word includes it
  assign shift_en  = SDIN_VALID;
  assign word      = sh_shifted;
`endif

  assign handshake = Q_VALID & Q_READY;
  assign load      = complete & (~Q_VALID | Q_READY);

  // bit counter: wraps on the completing bit, cleared by a SYNC without data
  always_comb begin
    cnt_next = cnt;
    if (SDIN_VALID) begin
      cnt_next = last_bit ? '0 : (cnt_base + CW'(1));
    end else if (SYNC) begin
      cnt_next = '0;
    end
  end

  // assembly path: shift register, bit counter and registered busy flag
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      sh   <= '0;
      cnt  <= '0;
      BUSY <= 1'b0;
    end else begin
      if (shift_en) begin
        sh <= sh_shifted;
      end else if (SYNC) begin
        sh <= '0;
      end
      cnt  <= cnt_next;
      BUSY <= (cnt_next != '0);
    end
  end

  // one-entry holding register: zero-bubble reload on handshake, drop and flag when stalled
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      Q        <= '0;
      Q_VALID  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (load) begin
        Q       <= word;
        Q_VALID <= 1'b1;
      end else if (handshake) begin
        Q_VALID <= 1'b0;
      end
      if (complete & Q_VALID & ~Q_READY) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

`ifdef SHIFT_WORD_DESER_PARITY_EN
  // parity flag travels with Q under the same load and drop rules
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      PERR <= 1'b0;
    end else if (load) begin
      PERR <= word_perr;
    end
  end
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_shift_word_deser.sv
// tb/tb_shift_word_deser.sv - randomized self-checking bench for shift_word_deser (both bit orders)
`timescale 1ns/1ps
module tb_shift_word_deser;
  localparam int W = 8;
`ifdef SHIFT_WORD_DESER_PARITY_EN
  localparam int L   = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         sclr = 1'b1, sdin = 1'b0, sdin_valid = 1'b0, sync = 1'b0, q_ready = 1'b0;
  logic [W-1:0] q0, q1;
  logic         qv0, qv1, busy0, busy1, ovf0, ovf1, perr0, perr1;

  always #5 clk = ~clk;

  shift_word_deser #(.C_WIDTH(W), .C_BIT_ORDER(0)) dut0 (
    .CLK(clk), .SCLR(sclr), .SDIN(sdin), .SDIN_VALID(sdin_valid), .SYNC(sync),
    .Q(q0), .Q_VALID(qv0), .Q_READY(q_ready), .BUSY(busy0), .OVERFLOW(ovf0), .PERR(perr0)
  );

  shift_word_deser #(.C_WIDTH(W), .C_BIT_ORDER(1)) dut1 (
    .CLK(clk), .SCLR(sclr), .SDIN(sdin), .SDIN_VALID(sdin_valid), .SYNC(sync),
    .Q(q1), .Q_VALID(qv1), .Q_READY(q_ready), .BUSY(busy1), .OVERFLOW(ovf1), .PERR(perr1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: the bits of the word in progress, and the buffered word
  bit           m_bits[$];
  logic [W-1:0] m_q0 = '0, m_q1 = '0;
  logic         m_valid = 1'b0, m_ovf = 1'b0, m_perr = 1'b0, m_busy = 1'b0;

  task automatic step(input bit r, input bit v, input bit b, input bit s, input bit rdy);
    logic [W-1:0] w0, w1;
    bit           p;
    bit           done;
    sclr = r; sdin_valid = v; sdin = b; sync = s; q_ready = rdy;
    @(posedge clk);
    #1;
    done = 1'b0; w0 = '0; w1 = '0; p = 1'b0;
    if (r) begin
      m_bits.delete();
      m_q0 = '0; m_q1 = '0; m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    end else begin
      if (s) m_bits.delete();
      if (v) m_bits.push_back(b);
      if (m_bits.size() == L) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          w0[W-1-i] = m_bits[i];
          w1[i]     = m_bits[i];
        end
        if (PAR) p = (^w0) ^ m_bits[L-1];
        m_bits.delete();
      end
      if (done && (!m_valid || rdy)) begin
        m_q0 = w0; m_q1 = w1; m_perr = p; m_valid = 1'b1;
      end else if (done) begin
        m_ovf = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    m_busy = (m_bits.size() != 0);
  endtask

  task automatic send_word(input logic [W-1:0] val, input int gap, input bit rdy, input bit rdy_last, input bit bad_par);
    for (int i = 0; i < L; i++) begin
      bit b;
      b = (i < W) ? val[W-1-i] : ((^val) ^ bad_par);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
      step(1'b0, 1'b1, b, 1'b0, (i == L-1) ? rdy_last : rdy);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (q0 !== 8'h00)  begin n_fail++; $display("FAIL reset_q0: got %h want 00", q0); end
    n_checks++; if (q1 !== 8'h00)  begin n_fail++; $display("FAIL reset_q1: got %h want 00", q1); end
    n_checks++; if (qv0 !== 1'b0)  begin n_fail++; $display("FAIL reset_qv: got %b want 0", qv0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    n_checks++; if (perr0 !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr0); end
  endtask

  task automatic test_bit_order();
    logic [W-1:0] pat;
    pat = 8'hC0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < L; i++) begin
      bit b;
      b = (i < W) ? pat[W-1-i] : (^pat);
      step(1'b0, 1'b1, b, 1'b0, 1'b1);
      n_checks++; if (busy0 !== (i != L-1)) begin n_fail++; $display("FAIL order_busy bit %0d: got %b want %b", i, busy0, (i != L-1)); end
      n_checks++; if (qv0 !== (i == L-1)) begin n_fail++; $display("FAIL order_qv bit %0d: got %b want %b", i, qv0, (i == L-1)); end
    end
    n_checks++; if (q0 !== 8'hC0) begin n_fail++; $display("FAIL order_msb_q: got %h want c0", q0); end
    n_checks++; if (q1 !== 8'h03) begin n_fail++; $display("FAIL order_lsb_q: got %h want 03", q1); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (qv0 !== 1'b0) begin n_fail++; $display("FAIL order_qv_one_cycle: got %b want 0", qv0); end
    n_checks++; if (q0 !== 8'hC0) begin n_fail++; $display("FAIL order_q_hold: got %h want c0", q0); end
    send_word(8'hC0, 3, 1'b1, 1'b1, 1'b0);
    n_checks++; if (qv0 !== 1'b1) begin n_fail++; $display("FAIL gap_qv: got %b want 1", qv0); end
    n_checks++; if (q0 !== 8'hC0) begin n_fail++; $display("FAIL gap_msb_q: got %h want c0", q0); end
    n_checks++; if (q1 !== 8'h03) begin n_fail++; $display("FAIL gap_lsb_q: got %h want 03", q1); end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (qv0 !== 1'b1) begin n_fail++; $display("FAIL ovf_first_qv: got %b want 1", qv0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_first_flag: got %b want 0", ovf0); end
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (q0 !== 8'hA5) begin n_fail++; $display("FAIL ovf_q_kept: got %h want a5", q0); end
    n_checks++; if (q1 !== 8'hA5) begin n_fail++; $display("FAIL ovf_q1_kept: got %h want a5", q1); end
    n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (qv0 !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_qv: got %b want 0", qv0); end
    n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pat;
    pat = 8'h22;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (q0 !== 8'h11) begin n_fail++; $display("FAIL b2b_first_q: got %h want 11", q0); end
    for (int i = 0; i < L; i++) begin
      bit b;
      b = (i < W) ? pat[W-1-i] : (^pat);
      step(1'b0, 1'b1, b, 1'b0, (i == L-1));
      n_checks++; if (qv0 !== 1'b1) begin n_fail++; $display("FAIL b2b_qv bit %0d: got %b want 1", i, qv0); end
    end
    n_checks++; if (q0 !== 8'h22) begin n_fail++; $display("FAIL b2b_q: got %h want 22", q0); end
    n_checks++; if (q1 !== 8'h44) begin n_fail++; $display("FAIL b2b_q1: got %h want 44", q1); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", ovf0); end
  endtask

  task automatic test_sync();
    logic [4:0] pre;
    pre = 5'b10110;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, pre[4-i], 1'b0, 1'b1);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL sync_busy_pre: got %b want 1", busy0); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    if (PAR) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if (qv0 !== 1'b1) begin n_fail++; $display("FAIL sync_qv: got %b want 1", qv0); end
    n_checks++; if (q0 !== 8'h80) begin n_fail++; $display("FAIL sync_q: got %h want 80", q0); end
    n_checks++; if (q1 !== 8'h01) begin n_fail++; $display("FAIL sync_q1: got %h want 01", q1); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL sync_idle_busy: got %b want 0", busy0); end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, pre[i], 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL sclr_mid_busy: got %b want 0", busy0); end
    n_checks++; if (qv0 !== 1'b0) begin n_fail++; $display("FAIL sclr_mid_qv: got %b want 0", qv0); end
    send_word(8'h36, 0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (q0 !== 8'h36) begin n_fail++; $display("FAIL sclr_clean_q: got %h want 36", q0); end
    n_checks++; if (q1 !== 8'h6C) begin n_fail++; $display("FAIL sclr_clean_q1: got %h want 6c", q1); end
  endtask

`ifdef SHIFT_WORD_DESER_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hC0, 0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (perr0 !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b want 0", perr0); end
    n_checks++; if (q0 !== 8'hC0) begin n_fail++; $display("FAIL par_good_q: got %h want c0", q0); end
    send_word(8'hC0, 0, 1'b1, 1'b1, 1'b1);
    n_checks++; if (perr0 !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b want 1", perr0); end
    n_checks++; if (perr1 !== 1'b1) begin n_fail++; $display("FAIL par_bad_lsb: got %b want 1", perr1); end
    n_checks++; if (q0 !== 8'hC0) begin n_fail++; $display("FAIL par_bad_q: got %h want c0", q0); end
  endtask
`endif

  task automatic test_random();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      bit r, v, b, s, rdy;
      r   = ($urandom_range(0, 249) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, v, b, s, rdy);
      n_checks++; if (q0 !== m_q0) begin n_fail++; $display("FAIL rnd_q0 cyc %0d: got %h want %h", c, q0, m_q0); end
      n_checks++; if (q1 !== m_q1) begin n_fail++; $display("FAIL rnd_q1 cyc %0d: got %h want %h", c, q1, m_q1); end
      n_checks++; if (qv0 !== m_valid || qv1 !== m_valid) begin n_fail++; $display("FAIL rnd_qv cyc %0d: got %b/%b want %b", c, qv0, qv1, m_valid); end
      n_checks++; if (busy0 !== m_busy || busy1 !== m_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b/%b want %b", c, busy0, busy1, m_busy); end
      n_checks++; if (ovf0 !== m_ovf || ovf1 !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d: got %b/%b want %b", c, ovf0, ovf1, m_ovf); end
      n_checks++; if (perr0 !== m_perr || perr1 !== m_perr) begin n_fail++; $display("FAIL rnd_perr cyc %0d: got %b/%b want %b", c, perr0, perr1, m_perr); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bit_order();
    test_overflow();
    test_back_to_back();
    test_sync();
`ifdef SHIFT_WORD_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
